// File: rtl/serv_ram32_resp.sv
// serv_ram32_resp
// Responder end of the RAM32 port holding the SERV register file. DEPTH x 32
// synchronous memory with byte-lane write enables and a registered 1-cycle
// read. After reset an optional zero-fill sweep runs with o_ready held low.
//
// Optional feature macro: RAM32_PARITY_EN
//   defined   -> 4 even-parity bits per word, checked on every read, o_par_err
//   undefined -> no parity storage, o_par_err tied 0
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_ram_addr  word address (modulo DEPTH)
//   i_ram_din   write data
//   i_ram_we    byte-lane write enables; all zero with i_ram_en = read
//   i_ram_en    access strobe, honoured only while o_ready is high
//   o_ram_dout  registered read data
//   o_ready     high once the block accepts accesses
//   o_par_err   registered parity error, aligned with o_ram_dout
module serv_ram32_resp #(
   parameter int unsigned DEPTH          = 32,
   parameter int unsigned ADDR_W         = $clog2(DEPTH),
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_ram_addr,
   input  logic [31:0]       i_ram_din,
   input  logic [3:0]        i_ram_we,
   input  logic              i_ram_en,
   output logic [31:0]       o_ram_dout,
   output logic              o_ready,
   output logic              o_par_err
);

   typedef enum logic {StClear, StRun} state_e;

   localparam state_e            RstState = CLEAR_ON_RESET ? StClear : StRun;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e            r_state, w_state_next;
   logic [ADDR_W-1:0] r_cnt, w_cnt_next;
   logic              r_ready, w_ready_next;
   logic [31:0]       r_dout;

   logic [3:0]        w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [31:0]       w_mem_wdata;
   logic              w_rd;

   logic [31:0]       r_mem [DEPTH];

   // Next-state and memory port selection
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_ready_next = r_ready;
      w_mem_we     = 4'h0;
      w_mem_addr   = i_ram_addr;
      w_mem_wdata  = i_ram_din;
      w_rd         = 1'b0;
      unique case (r_state)
         StClear: begin
            // Sweep owns the array; upstream inputs are ignored
            w_mem_we    = 4'hF;
            w_mem_addr  = r_cnt;
            w_mem_wdata = 32'h0;
            w_cnt_next  = r_cnt + 1'b1;
            if (r_cnt == LastAddr) begin
               w_state_next = StRun;
               w_ready_next = 1'b1;
            end
         end
         StRun: begin
            w_ready_next = 1'b1;
            // Accesses before o_ready rises are dropped
            if (r_ready && i_ram_en) begin
               if (|i_ram_we) w_mem_we = i_ram_we;
               else           w_rd     = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RstState;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_dout  <= 32'h0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_ready <= w_ready_next;
         if (w_rd) r_dout <= r_mem[i_ram_addr];
      end
   end

   // Array has no reset; writes are suppressed while reset is held
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_rst_n && w_mem_we[b]) r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
   end

`ifdef RAM32_PARITY_EN
   logic [3:0] r_par [DEPTH];
   logic [3:0] w_wpar;
   logic [3:0] w_rpar;
   logic [31:0] w_rword;
   logic        r_par_err;

   assign w_rword = r_mem[i_ram_addr];

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         w_wpar[b] = ^w_mem_wdata[8*b +: 8];
         w_rpar[b] = ^w_rword[8*b +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_rst_n && w_mem_we[b]) r_par[w_mem_addr][b] <= w_wpar[b];
      end
   end

   // Pulses for exactly the cycle the checked data is presented
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_par_err <= 1'b0;
      else          r_par_err <= w_rd && (w_rpar != r_par[i_ram_addr]);
   end

   assign o_par_err = r_par_err;
`else
   assign o_par_err = 1'b0;
`endif

   assign o_ram_dout = r_dout;
   assign o_ready    = r_ready;

endmodule

// File: tb/tb_serv_ram32_resp.sv
module tb_serv_ram32_resp;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] din = '0;
   logic [3:0]  we = '0;
   logic        en = 1'b0;
   logic [31:0] dout;
   logic        ready;
   logic        par_err;

   int n_checks = 0;
   int n_fails  = 0;

   serv_ram32_resp #(.DEPTH(DEPTH)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_ram_addr(addr),
      .i_ram_din (din),
      .i_ram_we  (we),
      .i_ram_en  (en),
      .o_ram_dout(dout),
      .o_ready   (ready),
      .o_par_err (par_err)
   );

   always #5 clk = ~clk;

   // Reference model: word array, edges since reset, expected outputs
   logic [31:0] m_mem [DEPTH];
   logic [3:0]  m_bad [DEPTH];
   logic [31:0] m_dout;
   logic        m_ready;
   logic        m_par;
   int          m_edges;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dout = 0; m_ready = 0; m_par = 0; m_edges = 0;
         // After the sweep every word reads zero; nothing is readable before that
         for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_bad[i] = 0; end
      end else begin
         m_par = 0;
         if (m_ready && en) begin
            if (we != 0) begin
               for (int b = 0; b < 4; b++)
                  if (we[b]) begin
                     m_mem[addr][8*b +: 8] = din[8*b +: 8];
                     m_bad[addr][b] = 1'b0;
                  end
            end else begin
               m_dout = m_mem[addr];
               m_par  = |m_bad[addr];
            end
         end
         m_edges++;
         if (m_edges >= DEPTH) m_ready = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("dout", dout, m_dout);
         chk("ready", {31'h0, ready}, {31'h0, m_ready});
         chk("par_err", {31'h0, par_err}, {31'h0, m_par});
      end
   end

   task automatic acc(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w,
                      input logic e);
      @(negedge clk);
      addr = a; din = d; we = w; en = e;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_dout"}, dout, 32'h0);
      chk({tag, "_ready"}, {31'h0, ready}, 32'h0);
      chk({tag, "_par"}, {31'h0, par_err}, 32'h0);
   endtask

   task automatic read_all;
      for (int i = 0; i < DEPTH; i++) acc(5'(i), 32'h0, 4'h0, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      chk_reset_outputs("rst0");
      @(negedge clk);
      rst_n = 1'b1;
      // o_ready low for 31 edges, high after the 32nd
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk); #1;
         chk("ready_edge", {31'h0, ready}, {31'h0, (i >= DEPTH)});
      end
      read_all();

      // Full write then read-back
      acc(5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
      acc(5'd5, 32'h0, 4'h0, 1'b1);
      chk("dout_hold_on_write", dout, 32'h0);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("readback_5", dout, 32'hDEADBEEF);

      // Mixed-lane write
      acc(5'd7, 32'h11223344, 4'hF, 1'b1);
      acc(5'd7, 32'hAABBCCDD, 4'b0101, 1'b1);
      acc(5'd7, 32'h0, 4'h0, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("mixed_lane_7", dout, 32'h11BB33DD);

      // Read then idle hold
      acc(5'd3, 32'hCAFEF00D, 4'hF, 1'b1);
      acc(5'd3, 32'h0, 4'h0, 1'b1);
      repeat (4) acc(5'($urandom), $urandom, 4'($urandom), 1'b0);
      chk("idle_hold_3", dout, 32'hCAFEF00D);

      // Random traffic
      for (int i = 0; i < 1500; i++)
         acc(5'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
             1'($urandom));
      acc(5'd0, 32'h0, 4'h0, 1'b0);

      // Reset mid-sweep, accesses while not ready are dropped
      @(negedge clk); rst_n = 1'b0; #1;
      chk_reset_outputs("rst1");
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0; #1;
      chk_reset_outputs("rst_mid");
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) acc(5'(i), 32'hFFFFFFFF, 4'hF, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("ready_after_sweep", {31'h0, ready}, 32'h1);
      read_all();
      acc(5'd9, 32'h0, 4'h0, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("dropped_write_9", dout, 32'h0);

`ifdef RAM32_PARITY_EN
      // Corrupt one stored bit and read it back
      @(negedge clk);
      dut.r_mem[2] = dut.r_mem[2] ^ 32'h0000_0200;
      m_mem[2] = m_mem[2] ^ 32'h0000_0200;
      m_bad[2][1] = 1'b1;
      acc(5'd2, 32'h0, 4'h0, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("par_err_pulse", {31'h0, par_err}, 32'h1);
      chk("par_err_data", dout, 32'h0000_0200);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("par_err_drop", {31'h0, par_err}, 32'h0);
      acc(5'd4, 32'h0, 4'h0, 1'b1);
      acc(5'd0, 32'h0, 4'h0, 1'b0);
      chk("par_clean", {31'h0, par_err}, 32'h0);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
